// File: rtl/pipe_pkg.sv
// Shared pipeline types: control bundle carried from decode to execute,
// ALU operation encoding and the default datapath/index widths.
package pipe_pkg;

  localparam int PIPE_WIDTH = 32;
  localparam int PIPE_INDEX = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    jump;
    alu_op_t alu_op;
  } ctrl_t;

  // All-zero control word: no side effects in later stages.
  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-side inputs and execute-side registered outputs of the ID/EX stage.
// There is no per-transfer ready: a stage transfer happens on every rising
// clk edge unless hold_in freezes it; idex_valid_out marks a real instruction
// and a cleared valid (with zero control) is a bubble.
interface id_ex_reg_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int INDEX = PIPE_INDEX
);
  logic             id_valid_in;
  logic [WIDTH-1:0] id_pc_in;
  logic [INDEX-1:0] id_rs1_in;
  logic [INDEX-1:0] id_rs2_in;
  logic [INDEX-1:0] id_rd_in;
  logic [WIDTH-1:0] id_rs1_data_in;
  logic [WIDTH-1:0] id_rs2_data_in;
  logic [WIDTH-1:0] id_imm_in;
  ctrl_t            id_ctrl_in;

  logic             idex_valid_out;
  logic [WIDTH-1:0] idex_pc_out;
  logic [INDEX-1:0] idex_rs1_out;
  logic [INDEX-1:0] idex_rs2_out;
  logic [INDEX-1:0] idex_rd_out;
  logic [WIDTH-1:0] idex_rs1_data_out;
  logic [WIDTH-1:0] idex_rs2_data_out;
  logic [WIDTH-1:0] idex_imm_out;
  ctrl_t            idex_ctrl_out;

  // Decode stage side: drives decoded fields, sees the latched copies.
  modport master (
    output id_valid_in, id_pc_in, id_rs1_in, id_rs2_in, id_rd_in,
           id_rs1_data_in, id_rs2_data_in, id_imm_in, id_ctrl_in,
    input  idex_valid_out, idex_pc_out, idex_rs1_out, idex_rs2_out, idex_rd_out,
           idex_rs1_data_out, idex_rs2_data_out, idex_imm_out, idex_ctrl_out
  );

  // Pipeline register side.
  modport slave (
    input  id_valid_in, id_pc_in, id_rs1_in, id_rs2_in, id_rd_in,
           id_rs1_data_in, id_rs2_data_in, id_imm_in, id_ctrl_in,
    output idex_valid_out, idex_pc_out, idex_rs1_out, idex_rs2_out, idex_rd_out,
           idex_rs1_data_out, idex_rs2_data_out, idex_imm_out, idex_ctrl_out
  );
endinterface

// File: rtl/load_use_hdu.sv
// Load-use hazard detector: a load sitting in EX whose destination is read by
// the instruction in ID cannot be forwarded in time, so ID must wait a cycle.
module load_use_hdu
  import pipe_pkg::*;
#(
  parameter int INDEX = PIPE_INDEX
) (
  input  logic             id_valid_i,
  input  logic [INDEX-1:0] id_rs1_i,
  input  logic [INDEX-1:0] id_rs2_i,
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [INDEX-1:0] ex_rd_i,
  input  logic             flush_i,
  output logic             stall_o
);

  // x0 is never a real dependency; a flush discards ID anyway.
  always_comb begin
    stall_o = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
              ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i)) && !flush_i;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, freeze, load-use bubble insertion and
// write-back bypass into the latched register-file operands.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int INDEX = PIPE_INDEX
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_reg_if.slave       bus,
  input  logic             memwb_reg_write_in,
  input  logic [INDEX-1:0] memwb_rd_in,
  input  logic [WIDTH-1:0] memwb_data_in,
  input  logic             flush_in,
  input  logic             hold_in,
  output logic             stall_out
);

  logic             valid_q,    valid_d;
  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [INDEX-1:0] rs1_q,      rs1_d;
  logic [INDEX-1:0] rs2_q,      rs2_d;
  logic [INDEX-1:0] rd_q,       rd_d;
  logic [WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [WIDTH-1:0] rs2_data_q, rs2_data_d;
  logic [WIDTH-1:0] imm_q,      imm_d;
  ctrl_t            ctrl_q,     ctrl_d;

  logic             stall;
  logic [WIDTH-1:0] rs1_byp, rs2_byp;

  load_use_hdu #(.INDEX(INDEX)) u_hdu (
    .id_valid_i    (bus.id_valid_in),
    .id_rs1_i      (bus.id_rs1_in),
    .id_rs2_i      (bus.id_rs2_in),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .flush_i       (flush_in),
    .stall_o       (stall)
  );

  assign stall_out = stall;

  // Write-back in the same cycle as decode: the register file read is stale,
  // so take the value being written instead (never for x0).
  always_comb begin
    rs1_byp = bus.id_rs1_data_in;
    rs2_byp = bus.id_rs2_data_in;
    if (memwb_reg_write_in && (memwb_rd_in != '0) && (memwb_rd_in == bus.id_rs1_in))
      rs1_byp = memwb_data_in;
    if (memwb_reg_write_in && (memwb_rd_in != '0) && (memwb_rd_in == bus.id_rs2_in))
      rs2_byp = memwb_data_in;
  end

  // Next state with priority flush > hold > load-use bubble > normal load.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    ctrl_d     = ctrl_q;
    if (flush_in) begin
      valid_d = 1'b0;
      ctrl_d  = ctrl_nop();
    end else if (!hold_in) begin
      if (stall) begin
        // Bubble: rd cleared so the bubble itself can never look like a load.
        valid_d = 1'b0;
        ctrl_d  = ctrl_nop();
        rd_d    = '0;
      end else begin
        valid_d    = bus.id_valid_in;
        pc_d       = bus.id_pc_in;
        rs1_d      = bus.id_rs1_in;
        rs2_d      = bus.id_rs2_in;
        rd_d       = bus.id_rd_in;
        rs1_data_d = rs1_byp;
        rs2_data_d = rs2_byp;
        imm_d      = bus.id_imm_in;
        ctrl_d     = bus.id_valid_in ? bus.id_ctrl_in : ctrl_nop();
      end
    end
  end

  // Stage register, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign bus.idex_valid_out    = valid_q;
  assign bus.idex_pc_out       = pc_q;
  assign bus.idex_rs1_out      = rs1_q;
  assign bus.idex_rs2_out      = rs2_q;
  assign bus.idex_rd_out       = rd_q;
  assign bus.idex_rs1_data_out = rs1_data_q;
  assign bus.idex_rs2_data_out = rs2_data_q;
  assign bus.idex_imm_out      = imm_q;
  assign bus.idex_ctrl_out     = ctrl_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for the ID/EX register: reset, load-use bubble, x0 handling,
// write-back bypass, flush/hold priority and mid-stream reset.
module tb_id_ex_reg;
  import pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int INDEX = 5;

  logic             clk;
  logic             rst_n;
  logic             memwb_reg_write_in;
  logic [INDEX-1:0] memwb_rd_in;
  logic [WIDTH-1:0] memwb_data_in;
  logic             flush_in;
  logic             hold_in;
  logic             stall_out;

  int n_checks;
  int n_fail;

  ctrl_t c_lw, c_add, c_sub;

  id_ex_reg_if #(.WIDTH(WIDTH), .INDEX(INDEX)) bus ();

  id_ex_reg #(.WIDTH(WIDTH), .INDEX(INDEX)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus.slave),
    .memwb_reg_write_in (memwb_reg_write_in),
    .memwb_rd_in        (memwb_rd_in),
    .memwb_data_in      (memwb_data_in),
    .flush_in           (flush_in),
    .hold_in            (hold_in),
    .stall_out          (stall_out)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [WIDTH-1:0] pc,
                          input logic [INDEX-1:0] rs1, input logic [INDEX-1:0] rs2,
                          input logic [INDEX-1:0] rd, input logic [WIDTH-1:0] d1,
                          input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] imm,
                          input ctrl_t c);
    bus.id_valid_in    = v;
    bus.id_pc_in       = pc;
    bus.id_rs1_in      = rs1;
    bus.id_rs2_in      = rs2;
    bus.id_rd_in       = rd;
    bus.id_rs1_data_in = d1;
    bus.id_rs2_data_in = d2;
    bus.id_imm_in      = imm;
    bus.id_ctrl_in     = c;
    #1;
  endtask

  task automatic drive_wb(input logic we, input logic [INDEX-1:0] rd, input logic [WIDTH-1:0] d);
    memwb_reg_write_in = we;
    memwb_rd_in        = rd;
    memwb_data_in      = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    c_lw  = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b1,
              alu_src: 1'b1, branch: 1'b0, jump: 1'b0, alu_op: ALU_ADD};
    c_add = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
              alu_src: 1'b0, branch: 1'b0, jump: 1'b0, alu_op: ALU_ADD};
    c_sub = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
              alu_src: 1'b0, branch: 1'b0, jump: 1'b0, alu_op: ALU_SUB};
    flush_in = 1'b0;
    hold_in  = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    drive_id(1'b1, 32'h0000_0100, 5'd2, 5'd3, 5'd5, 32'h11, 32'h22, 32'h4, c_lw);

    // Reset state
    rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(bus.idex_valid_out), 64'h0);
    check("rst_pc",    64'(bus.idex_pc_out),    64'h0);
    check("rst_rd",    64'(bus.idex_rd_out),    64'h0);
    check("rst_ctrl",  64'(bus.idex_ctrl_out),  64'h0);
    check("rst_stall", 64'(stall_out),          64'h0);
    rst_n = 1'b1;

    // lw x5, 4(x2) loads normally on first edge after reset release
    tick();
    check("lw_valid",  64'(bus.idex_valid_out),    64'h1);
    check("lw_pc",     64'(bus.idex_pc_out),       64'h100);
    check("lw_rd",     64'(bus.idex_rd_out),       64'h5);
    check("lw_rs1d",   64'(bus.idex_rs1_data_out), 64'h11);
    check("lw_imm",    64'(bus.idex_imm_out),      64'h4);
    check("lw_ctrl",   64'(bus.idex_ctrl_out),     64'h6C0);

    // add x6, x5, x1 -> load-use stall, bubble, then the add
    drive_id(1'b1, 32'h0000_0104, 5'd5, 5'd1, 5'd6, 32'h55, 32'h66, 32'h0, c_add);
    check("lu_stall", 64'(stall_out), 64'h1);
    tick();
    check("lu_bub_valid", 64'(bus.idex_valid_out), 64'h0);
    check("lu_bub_ctrl",  64'(bus.idex_ctrl_out),  64'h0);
    check("lu_bub_rd",    64'(bus.idex_rd_out),    64'h0);
    check("lu_stall_off", 64'(stall_out),          64'h0);
    tick();
    check("lu_add_valid", 64'(bus.idex_valid_out), 64'h1);
    check("lu_add_pc",    64'(bus.idex_pc_out),    64'h104);
    check("lu_add_rd",    64'(bus.idex_rd_out),    64'h6);
    check("lu_add_ctrl",  64'(bus.idex_ctrl_out),  64'(c_add));

    // lw x0 in EX, ID reads x0 -> no stall
    drive_id(1'b1, 32'h0000_0108, 5'd2, 5'd0, 5'd0, 32'h1, 32'h2, 32'h8, c_lw);
    tick();
    drive_id(1'b1, 32'h0000_010C, 5'd0, 5'd4, 5'd8, 32'h0, 32'h44, 32'h0, c_sub);
    check("x0_stall", 64'(stall_out), 64'h0);
    tick();
    check("x0_pc",    64'(bus.idex_pc_out),    64'h10C);
    check("x0_valid", 64'(bus.idex_valid_out), 64'h1);

    // Write-back bypass of x7, and no bypass of x0
    drive_wb(1'b1, 5'd7, 32'hDEAD_BEEF);
    drive_id(1'b1, 32'h0000_0110, 5'd3, 5'd7, 5'd9, 32'h33, 32'h1, 32'h0, c_add);
    tick();
    check("byp_rs2d", 64'(bus.idex_rs2_data_out), 64'hDEAD_BEEF);
    check("byp_rs1d", 64'(bus.idex_rs1_data_out), 64'h33);
    drive_wb(1'b1, 5'd0, 32'hCAFE_F00D);
    drive_id(1'b1, 32'h0000_0114, 5'd0, 5'd0, 5'd10, 32'h55, 32'h77, 32'h0, c_add);
    tick();
    check("byp_x0_rs1d", 64'(bus.idex_rs1_data_out), 64'h55);
    check("byp_x0_rs2d", 64'(bus.idex_rs2_data_out), 64'h77);
    drive_wb(1'b0, 5'd0, 32'h0);

    // Invalid decode: ctrl forced to zero
    drive_id(1'b0, 32'h0000_0118, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, c_lw);
    tick();
    check("inv_valid", 64'(bus.idex_valid_out), 64'h0);
    check("inv_ctrl",  64'(bus.idex_ctrl_out),  64'h0);

    // Flush beats hold and load-use
    drive_id(1'b1, 32'h0000_0120, 5'd1, 5'd1, 5'd5, 32'h0, 32'h0, 32'h0, c_lw);
    tick();
    drive_id(1'b1, 32'h0000_0124, 5'd5, 5'd1, 5'd6, 32'h0, 32'h0, 32'h0, c_add);
    flush_in = 1'b1;
    hold_in  = 1'b1;
    #1;
    check("fl_stall", 64'(stall_out), 64'h0);
    tick();
    check("fl_valid", 64'(bus.idex_valid_out), 64'h0);
    check("fl_ctrl",  64'(bus.idex_ctrl_out),  64'h0);
    flush_in = 1'b0;
    hold_in  = 1'b0;

    // Hold keeps everything for 3 cycles, also over a pending load-use
    drive_id(1'b1, 32'h0000_0200, 5'd1, 5'd2, 5'd9, 32'hA1, 32'hA2, 32'h20, c_lw);
    tick();
    hold_in = 1'b1;
    drive_id(1'b1, 32'h0000_0300, 5'd9, 5'd3, 5'd11, 32'hB1, 32'hB2, 32'h30, c_add);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 64'(bus.idex_valid_out),    64'h1);
      check("hold_pc",    64'(bus.idex_pc_out),       64'h200);
      check("hold_rd",    64'(bus.idex_rd_out),       64'h9);
      check("hold_rs1d",  64'(bus.idex_rs1_data_out), 64'hA1);
      check("hold_imm",   64'(bus.idex_imm_out),      64'h20);
      check("hold_ctrl",  64'(bus.idex_ctrl_out),     64'h6C0);
    end
    hold_in = 1'b0;
    #1;
    check("hold_rel_stall", 64'(stall_out), 64'h1);
    tick();
    check("hold_rel_bub", 64'(bus.idex_valid_out), 64'h0);

    // Mid-stream reset between edges
    tick();
    check("pre_rst_pc", 64'(bus.idex_pc_out), 64'h300);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 64'(bus.idex_valid_out),    64'h0);
    check("mrst_pc",    64'(bus.idex_pc_out),       64'h0);
    check("mrst_rs2d",  64'(bus.idex_rs2_data_out), 64'h0);
    check("mrst_ctrl",  64'(bus.idex_ctrl_out),     64'h0);
    check("mrst_stall", 64'(stall_out),             64'h0);
    tick();
    check("mrst_held", 64'(bus.idex_valid_out), 64'h0);
    drive_id(1'b1, 32'h0000_0400, 5'd1, 5'd2, 5'd12, 32'hC1, 32'hC2, 32'h0, c_sub);
    rst_n = 1'b1;
    tick();
    check("mrst_first_valid", 64'(bus.idex_valid_out), 64'h1);
    check("mrst_first_pc",    64'(bus.idex_pc_out),    64'h400);
    check("mrst_first_ctrl",  64'(bus.idex_ctrl_out),  64'(c_sub));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath and PC width.
REQ-002 SHALL have parameter INDEX, default 5, meaning register index width.
REQ-003 SHALL have clk  input  1  rising-edge clock; one clock domain.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have id_valid_in  input  1  decode holds a valid instruction.
REQ-006 SHALL have id_pc_in  input  WIDTH  decode PC.
REQ-007 SHALL have id_rs1_in, id_rs2_in, id_rd_in  input  INDEX each  decoded register indices.
REQ-008 SHALL have id_rs1_data_in, id_rs2_data_in, id_imm_in  input  WIDTH each  register-file reads and immediate.
REQ-009 SHALL have id_ctrl_in  input  ctrl_t  reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op[3:0].
REQ-010 SHALL have memwb_reg_write_in  input  1, memwb_rd_in  input  INDEX, memwb_data_in  input  WIDTH  write-back port.
REQ-011 SHALL have flush_in  input  1  branch/jump redirect from EX.
REQ-012 SHALL have hold_in  input  1  global pipeline freeze (memory wait).
REQ-013 SHALL have stall_out  output  1  load-use stall to PC and IF/ID register.
REQ-014 SHALL have idex_valid_out, idex_pc_out, idex_rs1_out, idex_rs2_out, idex_rd_out, idex_rs1_data_out, idex_rs2_data_out, idex_imm_out, idex_ctrl_out  output  registered copies of the inputs.

Function
REQ-015 SHALL register all idex_* outputs on rising clk; one-cycle latency ID to EX.
REQ-016 SHALL assert stall_out combinationally when id_valid_in & idex_valid_out & idex_ctrl_out.mem_read & idex_rd_out!=0 & (idex_rd_out==id_rs1_in | idex_rd_out==id_rs2_in) & !flush_in.
REQ-017 SHALL apply per-edge priority: flush_in > hold_in > stall_out bubble > normal load.
REQ-018 SHALL on flush_in clear idex_valid_out and all idex_ctrl_out bits, even with hold_in high.
REQ-019 SHALL on hold_in (no flush) keep every idex_* register unchanged.
REQ-020 SHALL on stall_out (no flush, no hold) insert a bubble: valid=0, ctrl=0, idex_rd_out=0; other fields don't-care.
REQ-021 SHALL otherwise load all decode inputs; valid=id_valid_in; ctrl forced 0 when id_valid_in=0.
REQ-022 SHALL bypass write-back into latched data: if memwb_reg_write_in & memwb_rd_in!=0 & memwb_rd_in==id_rsN_in, latch memwb_data_in as idex_rsN_data_out, else id_rsN_data_in.
REQ-023 SHALL never bypass or stall on register index 0.
REQ-024 SHALL treat stall_out as deasserted one cycle after the bubble, since the bubble clears idex_ctrl_out.mem_read.

Reset
REQ-025 SHALL on rst_n low immediately clear every idex_* output to 0, including valid and all ctrl bits.
REQ-026 SHALL hold stall_out at 0 while reset is asserted, since idex_valid_out is 0.
REQ-027 SHALL resume normal loading on the first rising edge after rst_n deasserts, including mid-program reset.

Structure
REQ-028 SHALL take ctrl_t (packed struct), alu_op_t (enum, 4 bits), WIDTH and INDEX defaults from the shared package pipe_pkg.
REQ-029 SHALL implement the REQ-016 compare in one combinational sub-module load_use_hdu; registers and bypass muxes stay in id_ex_reg.

Verification
REQ-030 SHALL cover load-use: EX holds lw x5 (mem_read=1, rd=5), ID holds add x6,x5,x1 -> stall_out=1, next edge valid=0/ctrl=0, the following edge loads the add.
REQ-031 SHALL cover the x0 case: EX lw x0, ID uses rs1=0 -> stall_out=0, normal load.
REQ-032 SHALL cover WB bypass: memwb writes x7=0xDEADBEEF, ID rs2=7 with stale id_rs2_data_in=0x1 -> idex_rs2_data_out=0xDEADBEEF.
REQ-033 SHALL cover priority: flush_in=1 with hold_in=1 and a load-use condition -> valid=0, ctrl=0 after the edge; with hold_in alone, all outputs unchanged for 3 cycles.
REQ-034 SHALL cover reset mid-stream: rst_n low between edges -> all outputs 0 immediately; after release, the first valid decode appears one edge later.
